// File: rtl/db_rr_arbiter_pkg.sv
// Shared constants, types and helpers for the DATA_BUS round-robin arbiter.
// The optional response timeout is enabled by defining DB_ARB_TIMEOUT_EN.
package db_rr_arbiter_pkg;

    localparam int DB_ARB_MAX_MASTERS = 8;
    localparam int DB_ARB_TIMEOUT     = 16;
    localparam int DB_ADDR_W          = 32;
    localparam int DB_DATA_W          = 32;

    // Index width that never collapses to zero bits (owner IDs, FIFO pointers).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_SLAVE,
        RESP_TIMEOUT
    } resp_src_e;

endpackage

// File: rtl/db_rr_arbiter_if.sv
// DATA_BUS request/response interface shared by requesters and the slave side.
// Master drives the request fields; Slave answers with gnt/rvalid/rdata/err/conf.
interface DATA_BUS;
    import db_rr_arbiter_pkg::*;

    logic                   req;
    logic                   we;
    logic [DB_DATA_W/8-1:0] be;
    logic [DB_ADDR_W-1:0]   addr;
    logic [DB_DATA_W-1:0]   wdata;
    logic                   gnt;
    logic                   rvalid;
    logic [DB_DATA_W-1:0]   rdata;
    logic                   err;
    logic                   conf;

    modport Master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err, conf
    );

    modport Slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err, conf
    );

endinterface

// File: rtl/db_owner_fifo.sv
// In-order FIFO of owner IDs for granted accesses still waiting on a response.
// A push is refused while full, even if a pop happens in the same cycle.
module db_owner_fifo
    import db_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/db_rr_arbiter.sv
// Round-robin arbiter sharing one DATA_BUS slave between NUM_MASTERS requesters.
// Optional response timeout: define DB_ARB_TIMEOUT_EN.
module db_rr_arbiter
    import db_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = DB_ARB_TIMEOUT
) (
    input  logic   clk,
    input  logic   rst,
    DATA_BUS.Slave  mst [NUM_MASTERS],
    DATA_BUS.Master slv
);

    localparam int OW = idx_width(NUM_MASTERS);
    typedef logic [OW-1:0] owner_id_t;

    if (NUM_MASTERS < 2 || NUM_MASTERS > DB_ARB_MAX_MASTERS) begin : g_bad_masters
        $error("db_rr_arbiter: NUM_MASTERS out of range");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("db_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] we_vec;
    logic [DB_DATA_W/8-1:0] be_arr    [NUM_MASTERS];
    logic [DB_ADDR_W-1:0]   addr_arr  [NUM_MASTERS];
    logic [DB_DATA_W-1:0]   wdata_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] gnt_vec;
    logic [NUM_MASTERS-1:0] rvalid_vec;

    owner_id_t          rr_q;
    owner_id_t          sel;
    owner_id_t          head;
    logic               found;
    int                 scan_idx;
    logic               any_req;
    logic               full;
    logic               empty;
    logic               grant;
    logic               pop;
    resp_src_e          resp_src;
    logic [DB_DATA_W-1:0] resp_rdata;
    logic               resp_err;

`ifdef DB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    // Interface arrays cannot take a run-time index, so flatten them here.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mst
        assign req_vec[i]    = mst[i].req;
        assign we_vec[i]     = mst[i].we;
        assign be_arr[i]     = mst[i].be;
        assign addr_arr[i]   = mst[i].addr;
        assign wdata_arr[i]  = mst[i].wdata;
        assign mst[i].gnt    = gnt_vec[i];
        assign mst[i].rvalid = rvalid_vec[i];
        assign mst[i].rdata  = rvalid_vec[i] ? resp_rdata : '0;
        assign mst[i].err    = rvalid_vec[i] && resp_err;
        assign mst[i].conf   = slv.conf;
    end

    // First requester at or after rr_q, scanning cyclically.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            scan_idx = (int'(rr_q) + k) % NUM_MASTERS;
            if (!found && req_vec[OW'(scan_idx)]) begin
                sel   = owner_id_t'(scan_idx);
                found = 1'b1;
            end
        end
    end

    assign any_req   = |req_vec;
    assign slv.req   = rst && any_req && !full;
    assign slv.we    = any_req ? we_vec[sel]    : 1'b0;
    assign slv.be    = any_req ? be_arr[sel]    : '0;
    assign slv.addr  = any_req ? addr_arr[sel]  : '0;
    assign slv.wdata = any_req ? wdata_arr[sel] : '0;
    assign grant     = slv.req && slv.gnt;

    always_comb begin
        gnt_vec = '0;
        if (grant) gnt_vec[sel] = 1'b1;
    end

    // A real slave response always beats a timeout landing in the same cycle.
    always_comb begin
        resp_src = RESP_NONE;
        if (!empty && slv.rvalid)
            resp_src = RESP_SLAVE;
`ifdef DB_ARB_TIMEOUT_EN
        else if (!empty && timeout_hit)
            resp_src = RESP_TIMEOUT;
`endif
        pop        = (resp_src != RESP_NONE);
        resp_rdata = (resp_src == RESP_SLAVE) ? slv.rdata : '0;
        resp_err   = (resp_src == RESP_SLAVE) ? slv.err : (resp_src == RESP_TIMEOUT);
        rvalid_vec = '0;
        if (pop) rvalid_vec[head] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_q <= '0;
        else if (grant)
            rr_q <= (sel == owner_id_t'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
    end

`ifdef DB_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (empty || pop)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`endif

    db_owner_fifo #(
        .WIDTH (OW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (pop),
        .din   (sel),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_db_rr_arbiter.sv
// Bench for db_rr_arbiter: directed scenarios, then random traffic against a queue-based model.
// Compile with DB_ARB_TIMEOUT_EN to add the response-timeout scenario.
`timescale 1ns/1ps
module tb_db_rr_arbiter;

    localparam int NM = 3;
    localparam int MO = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    DATA_BUS mst_if [NM] ();
    DATA_BUS slv_if ();

    logic [NM-1:0] m_req;
    logic [NM-1:0] m_we;
    logic [3:0]    m_be    [NM];
    logic [31:0]   m_addr  [NM];
    logic [31:0]   m_wdata [NM];
    logic [NM-1:0] o_gnt;
    logic [NM-1:0] o_rvalid;
    logic [NM-1:0] o_err;
    logic [NM-1:0] o_conf;
    logic [31:0]   o_rdata [NM];
    logic          s_gnt;
    logic          s_rvalid;
    logic          s_err;
    logic          s_conf;
    logic [31:0]   s_rdata;

    for (genvar i = 0; i < NM; i++) begin : g_m
        assign mst_if[i].req   = m_req[i];
        assign mst_if[i].we    = m_we[i];
        assign mst_if[i].be    = m_be[i];
        assign mst_if[i].addr  = m_addr[i];
        assign mst_if[i].wdata = m_wdata[i];
        assign o_gnt[i]        = mst_if[i].gnt;
        assign o_rvalid[i]     = mst_if[i].rvalid;
        assign o_err[i]        = mst_if[i].err;
        assign o_conf[i]       = mst_if[i].conf;
        assign o_rdata[i]      = mst_if[i].rdata;
    end

    assign slv_if.gnt    = s_gnt;
    assign slv_if.rvalid = s_rvalid;
    assign slv_if.rdata  = s_rdata;
    assign slv_if.err    = s_err;
    assign slv_if.conf   = s_conf;

    db_rr_arbiter #(
        .NUM_MASTERS     (NM),
        .MAX_OUTSTANDING (MO),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mst (mst_if),
        .slv (slv_if)
    );

    int errors = 0;
    int checks = 0;
    int rr_ref;
    int own_q[$];
    logic [32:0] rsp_q[$];
    logic [31:0] mem [16];
    int hold;
    logic [NM-1:0] seen_gnt;
    logic [NM-1:0] seen_rvalid;
    logic [NM-1:0] seen_err;
    logic [31:0]   seen_rdata0;
`ifdef DB_ARB_TIMEOUT_EN
    int wait_cnt;
    int to_at;
`endif

    task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        rr_ref = 0;
        own_q.delete();
        rsp_q.delete();
        hold = 0;
`ifdef DB_ARB_TIMEOUT_EN
        wait_cnt = 0;
`endif
    endtask

    task automatic set_master(input int i, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        m_req[i]   = r;
        m_we[i]    = w;
        m_be[i]    = 4'hF;
        m_addr[i]  = a;
        m_wdata[i] = d;
    endtask

    task automatic drive_slave(input bit eager);
        if (rsp_q.size() > 0 && (eager || hold >= 2 || $urandom_range(0, 3) != 0)) begin
            s_rvalid = 1'b1;
            {s_err, s_rdata} = rsp_q[0];
        end else begin
            s_rvalid = 1'b0;
            s_rdata  = $urandom;
            s_err    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic randomize_masters();
        for (int i = 0; i < NM; i++) begin
            if (!m_req[i] || seen_gnt[i]) begin
                m_req[i]   = ($urandom_range(0, 2) != 0);
                m_we[i]    = 1'($urandom_range(0, 1));
                m_be[i]    = 4'($urandom);
                m_addr[i]  = 32'($urandom_range(0, 15)) << 2;
                m_wdata[i] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_req = '0;
        s_rvalid = 1'b0;
        #1;
        reset_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One bus cycle: entered at negedge with inputs set, checks before posedge, model update at posedge.
    task automatic apply_stimulus();
        int sel;
        int owner;
        int depth;
        logic any;
        logic exp_req;
        logic exp_e;
        logic [31:0] exp_data;
        logic [31:0] a;
        logic [NM-1:0] exp_gnt;
        logic [NM-1:0] exp_rv;
        logic [NM-1:0] exp_err;

        #2;
        any     = |m_req;
        exp_req = any && (own_q.size() < MO);
        sel = 0;
        for (int k = NM - 1; k >= 0; k--)
            if (m_req[(rr_ref + k) % NM]) sel = (rr_ref + k) % NM;
        exp_gnt = '0;
        if (exp_req && s_gnt) exp_gnt[sel] = 1'b1;

        owner = -1;
        exp_data = '0;
        exp_e = 1'b0;
        if (own_q.size() > 0 && s_rvalid) begin
            owner = own_q[0];
            exp_data = s_rdata;
            exp_e = s_err;
        end
`ifdef DB_ARB_TIMEOUT_EN
        else if (own_q.size() > 0 && wait_cnt == TO - 1) begin
            owner = own_q[0];
            exp_e = 1'b1;
        end
`endif
        exp_rv = '0;
        exp_err = '0;
        if (owner >= 0) begin
            exp_rv[owner] = 1'b1;
            exp_err[owner] = exp_e;
        end

        check_output("slv_req", slv_if.req, exp_req);
        if (any)
            check_output("slv_fields", {slv_if.we, slv_if.be, slv_if.addr, slv_if.wdata},
                         {m_we[sel], m_be[sel], m_addr[sel], m_wdata[sel]});
        else
            check_output("slv_idle", {slv_if.we, slv_if.be, slv_if.addr, slv_if.wdata}, '0);
        check_output("gnt", o_gnt, exp_gnt);
        check_output("rvalid", o_rvalid, exp_rv);
        check_output("err", o_err, exp_err);
        for (int i = 0; i < NM; i++)
            check_output("rdata", o_rdata[i], (i == owner) ? exp_data : 32'h0);
        check_output("conf", o_conf, {NM{s_conf}});
        seen_gnt    = o_gnt;
        seen_rvalid = o_rvalid;
        seen_err    = o_err;
        seen_rdata0 = o_rdata[0];

        @(posedge clk);
        depth = own_q.size();
        if (owner >= 0) begin
            void'(own_q.pop_front());
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
        end
`ifdef DB_ARB_TIMEOUT_EN
        wait_cnt = (owner >= 0 || depth == 0) ? 0 : wait_cnt + 1;
`endif
        if (exp_gnt != '0) begin
            own_q.push_back(sel);
            rr_ref = (sel + 1) % NM;
            a = m_addr[sel];
            if (m_we[sel]) begin
                mem[a[5:2]] = m_wdata[sel];
                rsp_q.push_back({1'b0, 32'h0});
            end else begin
                rsp_q.push_back({($urandom_range(0, 7) == 0), mem[a[5:2]]});
            end
        end
        hold = (s_rvalid || rsp_q.size() == 0 || depth == 0) ? 0 : hold + 1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        m_req = '0;
        m_we = '0;
        for (int i = 0; i < NM; i++) set_master(i, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        s_gnt = 1'b0;
        s_rvalid = 1'b0;
        s_err = 1'b0;
        s_rdata = 32'h0;
        s_conf = 1'b0;
        seen_gnt = '0;
        reset_model();

        // Reset holds every grant path and response path low even with live inputs.
        m_req = 3'b011;
        s_gnt = 1'b1;
        s_rvalid = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        #12;
        check_output("rst_slv_req", slv_if.req, 1'b0);
        check_output("rst_gnt", o_gnt, '0);
        check_output("rst_rvalid", o_rvalid, '0);
        check_output("rst_err", o_err, '0);
        @(negedge clk);
        rst = 1'b1;
        m_req = '0;
        s_rvalid = 1'b0;

        // Single master write then read-back.
        set_master(0, 1'b1, 1'b1, 32'h0, 32'hA5);
        drive_slave(1);
        apply_stimulus();
        check_output("t1_gnt_m0", seen_gnt, 3'b001);
        set_master(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_slave(1);
        apply_stimulus();
        check_output("t1_wr_ack", seen_rvalid, 3'b001);
        m_req = '0;
        drive_slave(1);
        apply_stimulus();
        check_output("t1_rd_rvalid", seen_rvalid, 3'b001);
        check_output("t1_rd_data", seen_rdata0, 32'hA5);

        // Two persistent requesters alternate starting at M0.
        do_reset();
        set_master(0, 1'b1, 1'b0, 32'h4, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'h8, 32'h0);
        s_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_slave(1);
            apply_stimulus();
            check_output("alt_gnt", seen_gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
        end
        m_req = '0;
        repeat (2) begin
            drive_slave(1);
            apply_stimulus();
        end

        // Full FIFO blocks further grants, including the cycle of the first pop.
        do_reset();
        set_master(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'h14, 32'h0);
        s_gnt = 1'b1;
        repeat (2) begin
            s_rvalid = 1'b0;
            apply_stimulus();
        end
        for (int k = 0; k < 3; k++) begin
            s_rvalid = 1'b0;
            apply_stimulus();
            check_output("full_blocked", seen_gnt, 3'b000);
        end
        drive_slave(1);
        apply_stimulus();
        check_output("full_pop_no_push", seen_gnt, 3'b000);
        check_output("full_pop_owner", seen_rvalid, 3'b001);
        // Count 1: pop of M1 and push of M0 in the same cycle.
        drive_slave(1);
        apply_stimulus();
        check_output("popush_gnt", seen_gnt, 3'b001);
        check_output("popush_rvalid", seen_rvalid, 3'b010);
        m_req = '0;
        drive_slave(1);
        apply_stimulus();
        check_output("popush_head", seen_rvalid, 3'b001);
        drive_slave(1);
        apply_stimulus();

        // Reset mid-burst with two outstanding, then a stale response.
        do_reset();
        set_master(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'h24, 32'h0);
        s_gnt = 1'b1;
        repeat (2) begin
            s_rvalid = 1'b0;
            apply_stimulus();
        end
        s_rvalid = 1'b1;
        s_rdata = 32'h1234_5678;
        s_err = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_output("mid_rst_slv_req", slv_if.req, 1'b0);
        check_output("mid_rst_gnt", o_gnt, '0);
        check_output("mid_rst_rvalid", o_rvalid, '0);
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus();
        check_output("post_rst_gnt", seen_gnt, 3'b001);
        check_output("post_rst_stale", seen_rvalid, 3'b000);
        m_req = '0;
        repeat (2) begin
            drive_slave(1);
            apply_stimulus();
        end

`ifdef DB_ARB_TIMEOUT_EN
        // Slave never answers: the arbiter answers for it TO cycles after the grant.
        do_reset();
        set_master(1, 1'b1, 1'b0, 32'h30, 32'h0);
        s_gnt = 1'b1;
        s_rvalid = 1'b0;
        apply_stimulus();
        check_output("to_grant", seen_gnt, 3'b010);
        m_req = '0;
        to_at = -1;
        for (int k = 1; k <= TO + 4; k++) begin
            if (to_at < 0) begin
                s_rvalid = 1'b0;
                apply_stimulus();
                if (seen_rvalid != '0) to_at = k;
            end
        end
        check_output("to_cycle", to_at, TO);
        check_output("to_err", seen_err, 3'b010);
        s_rvalid = 1'b1;
        apply_stimulus();
        check_output("to_empty_after", seen_rvalid, 3'b000);
`endif

        // Random traffic on all masters with a randomly stalling slave.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            randomize_masters();
            s_gnt  = ($urandom_range(0, 3) != 0);
            s_conf = 1'($urandom_range(0, 1));
            drive_slave(0);
            apply_stimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
